// File: rtl/pulse_tx.sv
// pulse_tx: turns one-cycle event requests into level pulses on `out`.
// Each pulse is held high for HIGH_CYCLES and followed by at least LOW_CYCLES
// low, so a two-stage synchronizer at the far end always catches it.
// Requests that arrive while a pulse is in flight are counted in `pending` and
// replayed back to back. The counter saturates at 2**PEND_W-1.
// Build option: define PULSE_TX_OVERFLOW_EN to get a sticky `ovf` flag that is
// set whenever a request is dropped at saturation. Without it, `ovf` is tied
// low and no flop is built for it.
module pulse_tx #(
  parameter int HIGH_CYCLES = 3,
  parameter int LOW_CYCLES  = 3,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  // The counter only has to reach the longer of the two phase lengths.
  localparam int CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [PEND_W-1:0] pending_reg;
  logic [PEND_W-1:0] pending_next;
  logic              out_reg;
  logic              out_next;
  logic              pulse_start;  // this edge launches a new pulse
  logic              req_queue;    // req arrives while a pulse occupies the line

  // State, counter, queue depth and the pulse line itself are all registered.
  // Registering `out` keeps it glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pending_reg <= '0;
      out_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      out_reg     <= out_next;
    end
  end

  // Next-state logic: walk HIGH then LOW. At the end of LOW, either chain
  // straight into the next pulse or fall back to IDLE.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pulse_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next  = HIGH;
          cnt_next    = HIGH_LOAD;
          pulse_start = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = LOW;
          cnt_next   = LOW_LOAD;
        end
      end
      LOW: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if ((pending_reg != '0) || req) begin
          state_next  = HIGH;
          cnt_next    = HIGH_LOAD;
          pulse_start = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A request is queued only while the line is committed to a pulse and no
  // new pulse starts on this edge. A request that coincides with a pulse
  // start is consumed directly by that start.
  assign req_queue = req && ((state_reg == HIGH) ||
                             ((state_reg == LOW) && (cnt_reg != '0)));

  // Queue accounting: saturating increment on a queued req. Decrement when a
  // chained pulse start is served from the queue rather than by a live req.
  always_comb begin
    pending_next = pending_reg;
    if (req_queue) begin
      if (pending_reg != PEND_MAX) begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (pulse_start && (state_reg == LOW) && !req) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  // Output logic: the line is high exactly while the FSM sits in HIGH.
  // busy covers both an active pulse and queued work.
  always_comb begin
    out_next = (state_next == HIGH);
    busy     = (state_reg != IDLE) || (pending_reg != '0);
  end

  assign out     = out_reg;
  assign pending = pending_reg;

`ifdef PULSE_TX_OVERFLOW_EN
  logic ovf_reg;
  logic req_drop;

  // A request is lost when it must be queued but the queue is already full.
  assign req_drop = req_queue && (pending_reg == PEND_MAX);

  // Sticky overflow: once a request has been lost, stay set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (req_drop) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_tx.sv
// tb_pulse_tx: directed plus randomized checks of pulse_tx.
// Two DUTs share the same stimulus: one with the default queue width and one
// with PEND_W=2, so that saturation is easy to reach. Each DUT has its own
// reference model. The model works on a timeline: a pulse that starts at edge
// s is high after edges s..s+H-1 and low after edges s+H..s+H+L-1. Edge s+H+L
// is the point where the next pulse can chain on.
module tb_pulse_tx;

  localparam int H    = 3;
  localparam int L    = 3;
  localparam int PW_A = 4;
  localparam int PW_B = 2;
`ifdef PULSE_TX_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            req;
  logic            out_a, busy_a, ovf_a;
  logic [PW_A-1:0] pend_a;
  logic            out_b, busy_b, ovf_b;
  logic [PW_B-1:0] pend_b;

  pulse_tx #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW_A)) u_dut_a (
    .clk(clk), .reset(reset), .req(req),
    .out(out_a), .busy(busy_a), .pending(pend_a), .ovf(ovf_a)
  );

  pulse_tx #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW_B)) u_dut_b (
    .clk(clk), .reset(reset), .req(req),
    .out(out_b), .busy(busy_b), .pending(pend_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit active;   // a pulse (high + low gap) occupies the line
    int start;    // edge number at which the current pulse began
    int pend;     // queued requests
    bit dropped;  // some request has been lost to saturation since reset
  } model_t;

  model_t ma, mb;
  int     edge_no;
  int     n_cmp;
  int     n_err;
  int     rise_a, rise_b;
  logic   prev_a, prev_b;

  function automatic model_t model_reset();
    model_t m;
    m.active  = 1'b0;
    m.start   = 0;
    m.pend    = 0;
    m.dropped = 1'b0;
    return m;
  endfunction

  // Apply one clock edge e, with request r, to the timeline model.
  function automatic model_t model_edge(model_t m, int e, bit r, int cap);
    model_t n = m;
    if (!m.active) begin
      if (r) begin
        n.active = 1'b1;
        n.start  = e;
      end
    end else if (e - m.start < H + L) begin
      if (r) begin
        if (m.pend < cap) n.pend = m.pend + 1;
        else              n.dropped = 1'b1;
      end
    end else begin
      if (m.pend > 0 || r) begin
        n.start = e;
        if (!r) n.pend = m.pend - 1;
      end else begin
        n.active = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int e;
    e = edge_no;
    check("a.out",     out_a,  ma.active && (e - ma.start) < H);
    check("a.pending", pend_a, ma.pend);
    check("a.busy",    busy_a, ma.active || ma.pend != 0);
    check("a.ovf",     ovf_a,  OVF_EN && ma.dropped);
    check("b.out",     out_b,  mb.active && (e - mb.start) < H);
    check("b.pending", pend_b, mb.pend);
    check("b.busy",    busy_b, mb.active || mb.pend != 0);
    check("b.ovf",     ovf_b,  OVF_EN && mb.dropped);
  endtask

  // One clock with request r. Outputs are checked 1 time unit after the edge.
  task automatic step(input bit r);
    req = r;
    @(posedge clk);
    ma = model_edge(ma, edge_no, r, 2**PW_A - 1);
    mb = model_edge(mb, edge_no, r, 2**PW_B - 1);
    #1;
    compare_all();
    if (out_a && !prev_a) rise_a++;
    if (out_b && !prev_b) rise_b++;
    prev_a = out_a;
    prev_b = out_b;
    edge_no++;
  endtask

  task automatic do_reset();
    req   = 1'b0;
    reset = 1'b1;
    #1;
    ma     = model_reset();
    mb     = model_reset();
    prev_a = 1'b0;
    prev_b = 1'b0;
    compare_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    reset = 1'b0;
  endtask

  initial begin
    int dens[4];
    n_cmp   = 0;
    n_err   = 0;
    edge_no = 0;
    rise_a  = 0;
    rise_b  = 0;
    reset   = 1'b0;
    req     = 1'b0;
    ma      = model_reset();
    mb      = model_reset();
    prev_a  = 1'b0;
    prev_b  = 1'b0;
    #1;

    // Reset, then stay quiet: everything stays zero.
    do_reset();
    repeat (4) step(1'b0);
    $display("txn reset_idle done");

    // A single request gives 3 cycles high, 3 low, then back to idle.
    rise_a = 0;
    step(1'b1);
    check("single.first_high", out_a, 1);
    repeat (2) step(1'b0);
    check("single.third_high", out_a, 1);
    step(1'b0);
    check("single.first_low", out_a, 0);
    check("single.busy_low", busy_a, 1);
    repeat (2) step(1'b0);
    step(1'b0);
    check("single.busy_idle", busy_a, 0);
    check("single.pulses", rise_a, 1);
    $display("txn single_req pulses=%0d", rise_a);

    // Three back-to-back requests are queued and replayed with a gap of exactly L.
    rise_a = 0;
    step(1'b1);
    step(1'b1);
    check("three.pend1", pend_a, 1);
    step(1'b1);
    check("three.pend2", pend_a, 2);
    repeat (3) step(1'b0);
    step(1'b0);
    check("three.second_start_out", out_a, 1);
    check("three.second_start_pend", pend_a, 1);
    repeat (5) step(1'b0);
    step(1'b0);
    check("three.third_start_out", out_a, 1);
    check("three.third_start_pend", pend_a, 0);
    repeat (6) step(1'b0);
    check("three.busy_idle", busy_a, 0);
    check("three.pulses", rise_a, 3);
    $display("txn three_reqs pulses=%0d", rise_a);

    // Six requests in a row: the PEND_W=2 unit saturates at 3 and drops two.
    rise_a = 0;
    rise_b = 0;
    repeat (6) step(1'b1);
    check("sat.pend_b", pend_b, 3);
    check("sat.pend_a", pend_a, 5);
    check("sat.ovf_b", ovf_b, OVF_EN);
    check("sat.ovf_a", ovf_a, 0);
    repeat (40) step(1'b0);
    check("sat.pulses_b", rise_b, 4);
    check("sat.pulses_a", rise_a, 6);
    check("sat.busy_b", busy_b, 0);
    $display("txn saturate pulses_a=%0d pulses_b=%0d ovf_b=%0d", rise_a, rise_b, ovf_b);

    // A request on the exact edge where LOW ends starts the next pulse at once.
    do_reset();
    step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    check("lowend.out", out_a, 1);
    check("lowend.pend", pend_a, 0);
    repeat (8) step(1'b0);
    $display("txn req_at_low_end out=%0d", out_a);

    // Reset mid-HIGH with two requests queued clears everything before the next edge.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("midrst.pend_before", pend_a, 2);
    check("midrst.out_before", out_a, 1);
    req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    ma = model_reset();
    mb = model_reset();
    check("midrst.out_a", out_a, 0);
    check("midrst.pend_a", pend_a, 0);
    check("midrst.busy_a", busy_a, 0);
    check("midrst.out_b", out_b, 0);
    check("midrst.pend_b", pend_b, 0);
    @(posedge clk);
    #1;
    compare_all();
    reset  = 1'b0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    $display("txn reset_mid_high out=%0d pending=%0d", out_a, pend_a);

    // Random request traffic at several densities, then drain to idle.
    dens[0] = 15;
    dens[1] = 40;
    dens[2] = 75;
    dens[3] = 95;
    for (int d = 0; d < 4; d++) begin
      repeat (150) step($urandom_range(0, 99) < dens[d]);
      $display("txn random density=%0d pend_a=%0d pend_b=%0d", dens[d], pend_a, pend_b);
    end
    repeat (120) step(1'b0);
    check("drain.busy_a", busy_a, 0);
    check("drain.busy_b", busy_b, 0);
    $display("txn drain busy_a=%0d busy_b=%0d", busy_a, busy_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
